if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  IF stage of the 5-stage pipelined MIPS CPU, directly upstream of the ID-stage next-PC logic.
//  Owns PCF and issues one instruction-memory request at a time. Buffers a returned word while ID stalls.
//  Drives the IF/ID register (InstrD, PCPlus4D, ValidD). Applies the ID redirect (NPCD/IsJBrD) and syscall halt.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PCF value after reset
//  DELAY_SLOT  1              1: instr after jump/branch executes; 0: it is killed (bubble)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  StallD      in   1   hazard unit: ID cannot accept a new instruction this cycle
//  NPCD        in   32  redirect target from ID next-PC logic
//  IsJBrD      in   1   ID instr is a taken jump/branch
//  HaltD       in   1   ID instr is a halting syscall
//  imem_req    out  1   instruction fetch request
//  imem_addr   out  32  fetch address (= PCF)
//  imem_rdata  in   32  fetched word, valid when imem_ready
//  imem_ready  in   1   response for current request (>=0 cycles after req)
//  PCF         out  32  current fetch PC
//  InstrD      out  32  IF/ID instruction
//  PCPlus4D    out  32  IF/ID PC+4 of InstrD
//  ValidD      out  1   InstrD is a real instruction (0 = bubble)
//  HaltedF     out  1   fetch permanently stopped
// BEHAVIOUR
//  Reset (async): PCF=RESET_PC, InstrD=0, PCPlus4D=RESET_PC, ValidD=0, redirect/buffer cleared, state FETCH, HaltedF=0.
//  accept = !StallD. Redirect capture: IsJBrD&&ValidD&&accept -> RedirV=1, RedirT=NPCD.
//    RedirV/RedirT stays pending until the next delivery from PCF.
//  Halt capture: HaltD&&ValidD&&accept. Halt has priority over redirect.
//  Delivery from PCF = word at PCF moves into IF/ID.
//  redir = RedirV or a capture this cycle.
//    On delivery: PCF<=redir?target:PCF+4; RedirV<=0.
//    If DELAY_SLOT=0 && redir: IF/ID gets bubble (ValidD=0, InstrD=0), else {word, PCF+4, 1}.
//  Cycles where accept && no delivery: IF/ID <= bubble. !accept: IF/ID holds.
//  FSM:
//   FETCH: imem_req=1, addr=PCF held stable until ready.
//     ready&&accept -> deliver, stay FETCH (1 instr/cycle at zero-wait memory).
//     ready&&!accept -> BufR<=rdata, HOLD.
//     !ready -> stay.
//   HOLD: imem_req=0. accept -> deliver BufR, FETCH.
//   DRAIN: imem_req=1 until ready; response discarded -> HALT.
//   HALT: imem_req=0, ValidD=0, PCF frozen, HaltedF=1. Exit only via rst.
//   Halt capture: FETCH&&!ready -> DRAIN. FETCH&&ready or HOLD -> discard word, HALT.
//     IF/ID gets bubble; PCF not updated.
//  PCF+4 and PC arithmetic wrap mod 2^32; NPCD used verbatim (no alignment check).
//  rst mid-request: request abandoned; memory must tolerate req drop on reset.
// STRUCTURE
//  mips_defs.vh: FSM state encodings (FETCH/HOLD/DRAIN/HALT), NOP=32'h0, default RESET_PC.
//  One sub-module if_id_reg: async-reset IF/ID register with hold (!accept) and bubble inputs.
//  PC, FSM, buffer and redirect logic stay in this module.
// TESTING
//  T1 reset: rst pulse -> PCF=0x3000, ValidD=0, InstrD=0. Next cycle imem_req=1, imem_addr=0x3000.
//  T2 streaming: ready every cycle -> InstrD words of 0x3000,0x3004,0x3008 on consecutive cycles.
//     PCPlus4D=0x3004,0x3008,0x300C; ValidD=1.
//  T3 stall: StallD=1 for 3 cycles with ready -> HOLD, imem_req=0, IF/ID unchanged.
//     StallD=0 -> buffered word delivered, req resumes at next PC.
//  T4 branch: branch at 0x3000 in ID, IsJBrD=1, NPCD=0x3100, StallD=0.
//     DELAY_SLOT=1 -> word @0x3004 delivered ValidD=1, then addr=0x3100.
//     DELAY_SLOT=0 -> bubble, then addr=0x3100.
//  T5 slow memory: ready 2 cycles late while branch leaves ID -> RedirV pending, ID sees bubbles.
//     Delay slot delivered when ready arrives; next imem_addr=0x3100.
//  T6 halt: HaltD with request outstanding -> DRAIN until ready, then HALT.
//     imem_req=0, HaltedF=1, ValidD=0.
//     Async rst mid-HALT -> PCF=0x3000, HaltedF=0 immediately.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the IF fetch stage.
// FSM encodings, NOP word and default reset PC.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetchStateT;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Bubble wins over hold; hold keeps the current contents.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] instrNext,
  input  logic [31:0] pcPlus4Next,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP;
      PCPlus4D <= RESET_PC;
      ValidD   <= 1'b0;
    end else if (bubble) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!hold) begin
      InstrD   <= instrNext;
      PCPlus4D <= pcPlus4Next;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: owns PCF, single outstanding imem request,
// one-word stall buffer, ID redirect and syscall halt.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic [31:0] NPCD,
  input  logic        IsJBrD,
  input  logic        HaltD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        HaltedF
);

  fetchStateT  state;
  logic [31:0] bufR;
  logic        redirV;
  logic [31:0] redirT;

  logic        accept;
  logic        live;
  logic        capHalt;
  logic        capRedir;
  logic        redir;
  logic [31:0] target;
  logic        deliver;
  logic        kill;
  logic        ifBubble;
  logic [31:0] word;
  logic [31:0] pcPlus4;

  assign accept   = !StallD;
  assign live     = (state == FETCH) || (state == HOLD);
  assign capHalt  = live && HaltD && ValidD && accept;
  assign capRedir = live && IsJBrD && ValidD && accept && !capHalt;
  assign redir    = redirV || capRedir;
  assign target   = capRedir ? NPCD : redirT;
  assign pcPlus4  = PCF + 32'd4;
  assign word     = (state == HOLD) ? bufR : imem_rdata;

  assign deliver = accept && !capHalt &&
                   (((state == FETCH) && imem_ready) ||
                    (state == HOLD));

  assign kill = deliver && redir && (DELAY_SLOT == 0);

  // HALT flushes IF/ID even while ID is stalled
  assign ifBubble = (state == HALT) ||
                    (accept && (!deliver || kill));

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = PCF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      PCF     <= RESET_PC;
      bufR    <= NOP;
      redirV  <= 1'b0;
      redirT  <= 32'h0;
      HaltedF <= 1'b0;
    end else begin
      if (deliver) begin
        PCF    <= redir ? target : pcPlus4;
        redirV <= 1'b0;
      end else if (capRedir) begin
        redirV <= 1'b1;
        redirT <= NPCD;
      end
      unique case (state)
        FETCH: begin
          if (capHalt) begin
            state   <= imem_ready ? HALT : DRAIN;
            HaltedF <= imem_ready;
          end else if (imem_ready && !accept) begin
            bufR  <= imem_rdata;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (capHalt) begin
            state   <= HALT;
            HaltedF <= 1'b1;
          end else if (accept) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state   <= HALT;
            HaltedF <= 1'b1;
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

  if_id_reg #(
    .RESET_PC(RESET_PC)
  ) uIfId (
    .clk        (clk),
    .rst        (rst),
    .hold       (!accept),
    .bubble     (ifBubble),
    .instrNext  (word),
    .pcPlus4Next(pcPlus4),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage.
// Second instance exercises the killed delay slot.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD;
  logic [31:0] NPCD;
  logic        IsJBrD;
  logic        HaltD;
  logic        ready;

  logic        req1, req0;
  logic [31:0] addr1, addr0;
  logic [31:0] rdata1, rdata0;
  logic [31:0] pcf1, pcf0;
  logic [31:0] instr1, instr0;
  logic [31:0] pc4a, pc4b;
  logic        valid1, valid0;
  logic        halted1, halted0;

  int asserts = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign rdata1 = memWord(addr1);
  assign rdata0 = memWord(addr0);

  if_fetch_stage #(
    .RESET_PC  (32'h0000_3000),
    .DELAY_SLOT(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .StallD    (StallD),
    .NPCD      (NPCD),
    .IsJBrD    (IsJBrD),
    .HaltD     (HaltD),
    .imem_req  (req1),
    .imem_addr (addr1),
    .imem_rdata(rdata1),
    .imem_ready(ready),
    .PCF       (pcf1),
    .InstrD    (instr1),
    .PCPlus4D  (pc4a),
    .ValidD    (valid1),
    .HaltedF   (halted1)
  );

  if_fetch_stage #(
    .RESET_PC  (32'h0000_3000),
    .DELAY_SLOT(0)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .StallD    (StallD),
    .NPCD      (NPCD),
    .IsJBrD    (IsJBrD),
    .HaltD     (HaltD),
    .imem_req  (req0),
    .imem_addr (addr0),
    .imem_rdata(rdata0),
    .imem_ready(ready),
    .PCF       (pcf0),
    .InstrD    (instr0),
    .PCPlus4D  (pc4b),
    .ValidD    (valid0),
    .HaltedF   (halted0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    asserts++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    StallD = 1'b0;
    NPCD = 32'h0;
    IsJBrD = 1'b0;
    HaltD = 1'b0;
    ready = 1'b0;
    #2;
    chk("rst_pcf", pcf1, 32'h3000);
    chk("rst_valid", {31'b0, valid1}, 32'h0);
    chk("rst_instr", instr1, 32'h0);
    chk("rst_pc4", pc4a, 32'h3000);
    chk("rst_halted", {31'b0, halted1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t1_req", {31'b0, req1}, 32'h1);
    chk("t1_addr", addr1, 32'h3000);
    chk("t1_valid", {31'b0, valid1}, 32'h0);

    // T2 streaming
    ready = 1'b1;
    tick();
    chk("t2_i0", instr1, 32'h5A5A_3000);
    chk("t2_p0", pc4a, 32'h3004);
    chk("t2_v0", {31'b0, valid1}, 32'h1);
    tick();
    chk("t2_i1", instr1, 32'h5A5A_3004);
    chk("t2_p1", pc4a, 32'h3008);
    tick();
    chk("t2_i2", instr1, 32'h5A5A_3008);
    chk("t2_p2", pc4a, 32'h300C);
    chk("t2_pcf", pcf1, 32'h300C);

    // T3 stall with buffered response
    StallD = 1'b1;
    tick();
    chk("t3_req_a", {31'b0, req1}, 32'h0);
    chk("t3_hold_a", instr1, 32'h5A5A_3008);
    tick();
    tick();
    chk("t3_req_c", {31'b0, req1}, 32'h0);
    chk("t3_hold_c", instr1, 32'h5A5A_3008);
    chk("t3_vhold", {31'b0, valid1}, 32'h1);
    chk("t3_pcf", pcf1, 32'h300C);
    StallD = 1'b0;
    tick();
    chk("t3_buf", instr1, 32'h5A5A_300C);
    chk("t3_bufp4", pc4a, 32'h3010);
    chk("t3_req", {31'b0, req1}, 32'h1);
    chk("t3_addr", addr1, 32'h3010);

    // T4 branch with zero-wait memory
    IsJBrD = 1'b1;
    NPCD = 32'h3100;
    tick();
    IsJBrD = 1'b0;
    chk("t4_ds", instr1, 32'h5A5A_3010);
    chk("t4_dsv", {31'b0, valid1}, 32'h1);
    chk("t4_addr", addr1, 32'h3100);
    chk("t4_k_v", {31'b0, valid0}, 32'h0);
    chk("t4_k_i", instr0, 32'h0);
    chk("t4_k_addr", addr0, 32'h3100);
    tick();
    chk("t4_tgt", instr1, 32'h5A5A_3100);
    chk("t4_tgtp4", pc4a, 32'h3104);
    chk("t4_k_tgt", instr0, 32'h5A5A_3100);

    // T5 slow memory, redirect stays pending
    ready = 1'b0;
    IsJBrD = 1'b1;
    NPCD = 32'h3200;
    tick();
    IsJBrD = 1'b0;
    chk("t5_bub_a", {31'b0, valid1}, 32'h0);
    chk("t5_addr_a", addr1, 32'h3104);
    tick();
    chk("t5_bub_b", {31'b0, valid1}, 32'h0);
    chk("t5_addr_b", addr1, 32'h3104);
    chk("t5_req", {31'b0, req1}, 32'h1);
    ready = 1'b1;
    tick();
    chk("t5_ds", instr1, 32'h5A5A_3104);
    chk("t5_dsv", {31'b0, valid1}, 32'h1);
    chk("t5_addr", addr1, 32'h3200);

    // T6 halt with request outstanding
    ready = 1'b0;
    HaltD = 1'b1;
    tick();
    HaltD = 1'b0;
    chk("t6_drain_req", {31'b0, req1}, 32'h1);
    chk("t6_drain_h", {31'b0, halted1}, 32'h0);
    chk("t6_drain_v", {31'b0, valid1}, 32'h0);
    chk("t6_drain_pc", pcf1, 32'h3200);
    tick();
    chk("t6_drain2", {31'b0, req1}, 32'h1);
    ready = 1'b1;
    tick();
    chk("t6_halt_req", {31'b0, req1}, 32'h0);
    chk("t6_halted", {31'b0, halted1}, 32'h1);
    chk("t6_halt_v", {31'b0, valid1}, 32'h0);
    chk("t6_halt_pc", pcf1, 32'h3200);
    tick();
    chk("t6_stay_req", {31'b0, req1}, 32'h0);
    chk("t6_stay_pc", pcf1, 32'h3200);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_pc", pcf1, 32'h3000);
    chk("t6_rst_h", {31'b0, halted1}, 32'h0);
    chk("t6_rst_v", {31'b0, valid1}, 32'h0);
    #1;
    rst = 1'b0;

    // PC wrap through a redirect near the top of memory
    tick();
    chk("w_i0", instr1, 32'h5A5A_3000);
    IsJBrD = 1'b1;
    NPCD = 32'hFFFF_FFFC;
    tick();
    IsJBrD = 1'b0;
    chk("w_ds", instr1, 32'h5A5A_3004);
    chk("w_addr", addr1, 32'hFFFF_FFFC);
    tick();
    chk("w_top", instr1, 32'hA5A5_FFFC);
    chk("w_p4", pc4a, 32'h0000_0000);
    chk("w_pcf", pcf1, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
